// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory read arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int CNT_W = 3;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: round-robin on ties, or port 0 first when FIXED_PRIO is set.
module rr_pick2
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = PORT_IF;
    if (req0 && req1) begin
      grant_idx = FIXED_PRIO ? PORT_IF : ~last_owner;
    end else if (req1) begin
      grant_idx = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the registered read port of the word memory between instruction fetch (port 0)
// and the data port (port 1); each grant runs strobe -> wait -> one-cycle response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int FIXED_PRIO  = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req0,
  input  logic [31:0] addr0,
  output logic [31:0] rdata0,
  output logic        rvalid0,
  input  logic        req1,
  input  logic [31:0] addr1,
  output logic [31:0] rdata1,
  output logic        rvalid1,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state_dbg
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              mem_rstrb_q, mem_rstrb_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;

  logic grant_valid;
  logic grant_idx;

  rr_pick2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_rstrb_d  = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_idx;
          last_owner_d = grant_idx;
          mem_addr_d   = (grant_idx == PORT_D) ? addr1 : addr0;
          mem_rstrb_d  = 1'b1;
          state_d      = ST_STROBE;
        end
      end
      ST_STROBE: begin
        cnt_d   = LAT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // A count of 1 marks the cycle in which mem_rdata carries our word.
        if (cnt_q == CNT_W'(1)) begin
          if (owner_q == PORT_D) begin
            rdata1_d  = mem_rdata;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_rdata;
            rvalid0_d = 1'b1;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_IF;
      last_owner_q <= PORT_D;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_rstrb_q  <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_rstrb_q  <= mem_rstrb_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rstrb = mem_rstrb_q;
  assign state_dbg = state_q;

endmodule
